// File: rtl/dft_pkg.sv
// Shared state encoding and datapath widths for the two-bin DFT correlator.
package dft_pkg;
    localparam int SMP_W     = 18;
    localparam int PH_W      = 18;
    localparam int PROD_W    = SMP_W + PH_W;
    localparam int ADDR_W    = 9;
    localparam int ACC_W_DEF = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/cplx_mac.sv
// One DFT bin: sample times cos/sin phasor, accumulated as re += x*cos, im -= x*sin.
// Result registered on the enabling edge; clr has priority over en.
module cplx_mac
    import dft_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [SMP_W-1:0] smp,
    input  logic signed [PH_W-1:0]  cos_ph,
    input  logic signed [PH_W-1:0]  sin_ph,
    output logic signed [ACC_W-1:0] re,
    output logic signed [ACC_W-1:0] im
);
    logic signed [PROD_W-1:0] p_re;
    logic signed [PROD_W-1:0] p_im;

    assign p_re = smp * cos_ph;
    assign p_im = smp * sin_ph;

    // Full-precision products are sign-extended; the sums wrap at ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re <= '0;
            im <= '0;
        end else if (clr) begin
            re <= '0;
            im <= '0;
        end else if (en) begin
            re <= re + ACC_W'(p_re);
            im <= im - ACC_W'(p_im);
        end
    end
endmodule

// File: rtl/dft_bin_acc.sv
// Two-bin DFT correlator over an N-sample frame; done at S+PH_LAT+N (one later with DFT_BIN_ACC_MAG_EN).
// START restarts from any state; PH_LAT must be at least 2.
module dft_bin_acc
    import dft_pkg::*;
#(
    parameter int N      = 256,
    parameter int PH_LAT = 6,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic                     START,
    input  logic signed [PH_W-1:0]   cos0,
    input  logic signed [PH_W-1:0]   sin0,
    input  logic signed [PH_W-1:0]   cos1,
    input  logic signed [PH_W-1:0]   sin1,
    output logic [ADDR_W-1:0]        smp_addr,
    input  logic signed [SMP_W-1:0]  smp_data,
    output logic signed [ACC_W-1:0]  re0,
    output logic signed [ACC_W-1:0]  im0,
    output logic signed [ACC_W-1:0]  re1,
    output logic signed [ACC_W-1:0]  im1,
    output logic                     busy,
    output logic                     done
`ifdef DFT_BIN_ACC_MAG_EN
    ,
    output logic [ACC_W-1:0]         mag0,
    output logic [ACC_W-1:0]         mag1
`endif
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PH_LAT - 2);
    localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(N - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             acc_clr;
    logic             acc_en;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts wait cycles in WAIT and the sample index k in ACC.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        if (START) begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
            acc_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state_nxt = ACC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ACC: begin
                    acc_en = 1'b1;
                    if (cnt == LAST_K) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DONE: begin
`ifdef DFT_BIN_ACC_MAG_EN
                    if (cnt == '0) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Address runs one cycle ahead of the phasor index to cover the RAM read latency.
    assign smp_addr = (state == ACC && cnt != LAST_K) ? ADDR_W'(cnt + 1'b1) : '0;
    assign busy     = (state != IDLE);

`ifdef DFT_BIN_ACC_MAG_EN
    assign done = (state == DONE) && (cnt != '0) && !START;
`else
    assign done = (state == DONE) && !START;
`endif

    cplx_mac #(.ACC_W(ACC_W)) u_bin0 (
        .clk    (CK),
        .rst    (RST),
        .clr    (acc_clr),
        .en     (acc_en),
        .smp    (smp_data),
        .cos_ph (cos0),
        .sin_ph (sin0),
        .re     (re0),
        .im     (im0)
    );

    cplx_mac #(.ACC_W(ACC_W)) u_bin1 (
        .clk    (CK),
        .rst    (RST),
        .clr    (acc_clr),
        .en     (acc_en),
        .smp    (smp_data),
        .cos_ph (cos1),
        .sin_ph (sin1),
        .re     (re1),
        .im     (im1)
    );

`ifdef DFT_BIN_ACC_MAG_EN
    function automatic logic [ACC_W-1:0] abs_v(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
    endfunction

    // Alpha-max-plus-beta-min estimate with alpha=1, beta=1/2.
    function automatic logic [ACC_W-1:0] mag_est(input logic signed [ACC_W-1:0] a,
                                                 input logic signed [ACC_W-1:0] b);
        logic [ACC_W-1:0] aa;
        logic [ACC_W-1:0] bb;
        aa = abs_v(a);
        bb = abs_v(b);
        return (aa > bb) ? (aa + (bb >> 1)) : (bb + (aa >> 1));
    endfunction

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            mag0 <= '0;
            mag1 <= '0;
        end else if (state == DONE && cnt == '0) begin
            mag0 <= mag_est(re0, im0);
            mag1 <= mag_est(re1, im1);
        end
    end
`endif
endmodule

// File: tb/tb_dft_bin_acc.sv
// Bench for dft_bin_acc: an N=8 and an N=1 instance share START and phasors, checked against a sum-of-products model.
module tb_dft_bin_acc;
    localparam int NA     = 8;
    localparam int NB     = 1;
    localparam int PH_LAT = 6;
`ifdef DFT_BIN_ACC_MAG_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic        CK = 1'b0;
    logic        RST;
    logic        START;
    logic [17:0] cos0, sin0, cos1, sin1;
    logic [8:0]  addr_a, addr_b;
    logic [17:0] data_a, data_b;
    logic [47:0] re0_a, im0_a, re1_a, im1_a;
    logic [47:0] re0_b, im0_b, re1_b, im1_b;
    logic        busy_a, done_a, busy_b, done_b;
`ifdef DFT_BIN_ACC_MAG_EN
    logic [47:0] mag0_a, mag1_a, mag0_b, mag1_b;
`endif

    logic [17:0] mem  [NA];
    logic [17:0] t_c0 [NA];
    logic [17:0] t_s0 [NA];
    logic [17:0] t_c1 [NA];
    logic [17:0] t_s1 [NA];
    logic [47:0] exp_a [4];
    logic [47:0] exp_b [4];
    logic [47:0] expm_a [2];

    int checks   = 0;
    int failures = 0;

    always #5 CK = ~CK;

    dft_bin_acc #(.N(NA), .PH_LAT(PH_LAT), .ACC_W(48)) u_dut_a (
        .CK(CK), .RST(RST), .START(START),
        .cos0(cos0), .sin0(sin0), .cos1(cos1), .sin1(sin1),
        .smp_addr(addr_a), .smp_data(data_a),
        .re0(re0_a), .im0(im0_a), .re1(re1_a), .im1(im1_a),
        .busy(busy_a), .done(done_a)
`ifdef DFT_BIN_ACC_MAG_EN
        , .mag0(mag0_a), .mag1(mag1_a)
`endif
    );

    dft_bin_acc #(.N(NB), .PH_LAT(PH_LAT), .ACC_W(48)) u_dut_b (
        .CK(CK), .RST(RST), .START(START),
        .cos0(cos0), .sin0(sin0), .cos1(cos1), .sin1(sin1),
        .smp_addr(addr_b), .smp_data(data_b),
        .re0(re0_b), .im0(im0_b), .re1(re1_b), .im1(im1_b),
        .busy(busy_b), .done(done_b)
`ifdef DFT_BIN_ACC_MAG_EN
        , .mag0(mag0_b), .mag1(mag1_b)
`endif
    );

    // Sample RAM: one-cycle read latency.
    always @(posedge CK) begin
        data_a <= (addr_a < 9'(NA)) ? mem[addr_a[2:0]] : 18'h2AAAA;
        data_b <= (addr_b < 9'(NA)) ? mem[addr_b[2:0]] : 18'h2AAAA;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [17:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [47:0] mag_ref(input longint a, input longint b);
        longint aa, bb, r;
        aa = (a < 0) ? -a : a;
        bb = (b < 0) ? -b : b;
        r  = (aa > bb) ? aa + bb / 2 : bb + aa / 2;
        return r[47:0];
    endfunction

    // Reference: plain correlation sums over the first n samples.
    task automatic model(input int n, output logic [47:0] e[4], output logic [47:0] m[2]);
        longint r0 = 0, i0 = 0, r1 = 0, i1 = 0;
        for (int k = 0; k < n; k++) begin
            r0 += sx(mem[k]) * sx(t_c0[k]);
            i0 -= sx(mem[k]) * sx(t_s0[k]);
            r1 += sx(mem[k]) * sx(t_c1[k]);
            i1 -= sx(mem[k]) * sx(t_s1[k]);
        end
        e[0] = r0[47:0];
        e[1] = i0[47:0];
        e[2] = r1[47:0];
        e[3] = i1[47:0];
        m[0] = mag_ref(r0, i0);
        m[1] = mag_ref(r1, i1);
    endtask

    task automatic rand_ph();
        cos0 = 18'($urandom);
        sin0 = 18'($urandom);
        cos1 = 18'($urandom);
        sin1 = 18'($urandom);
    endtask

    task automatic rand_tabs();
        for (int k = 0; k < NA; k++) begin
            mem[k]  = 18'($urandom);
            t_c0[k] = 18'($urandom);
            t_s0[k] = 18'($urandom);
            t_c1[k] = 18'($urandom);
            t_s1[k] = 18'($urandom);
        end
    endtask

    task automatic chk_dut(input string tag, input int c, input int n,
                           input logic [8:0] addr, input logic busy, input logic done,
                           input logic [47:0] r0, input logic [47:0] i0,
                           input logic [47:0] r1, input logic [47:0] i1,
                           input logic [47:0] e[4]);
        int k;
        int ea;
        k  = c - (PH_LAT - 1);
        ea = (k >= 0 && k < n) ? k : 0;
        chk($sformatf("%s_addr_c%0d", tag, c), 64'(addr), 64'(ea));
        chk($sformatf("%s_done_c%0d", tag, c), 64'(done), 64'(c == PH_LAT + n + DLY));
        chk($sformatf("%s_busy_c%0d", tag, c), 64'(busy), 64'(c <= PH_LAT + n + DLY));
        if (c >= PH_LAT + n + DLY) begin
            chk($sformatf("%s_re0_c%0d", tag, c), 64'(r0), 64'(e[0]));
            chk($sformatf("%s_im0_c%0d", tag, c), 64'(i0), 64'(e[1]));
            chk($sformatf("%s_re1_c%0d", tag, c), 64'(r1), 64'(e[2]));
            chk($sformatf("%s_im1_c%0d", tag, c), 64'(i1), 64'(e[3]));
        end
    endtask

    // Drives one frame from its START cycle; stop_c > 0 ends it early so the caller's next START lands in cycle stop_c.
    task automatic run_frame(input string tag, input int stop_c);
        logic [47:0] mb [2];
        model(NA, exp_a, expm_a);
        model(NB, exp_b, mb);
        @(posedge CK); #1;
        START = 1'b1;
        rand_ph();
        #1;
        chk({tag, "_a_done_start"}, 64'(done_a), 64'(0));
        chk({tag, "_b_done_start"}, 64'(done_b), 64'(0));
        for (int c = 1; c <= PH_LAT + NA + DLY + 2; c++) begin
            if (c == stop_c) return;
            @(posedge CK); #1;
            START = 1'b0;
            if (c >= PH_LAT && c < PH_LAT + NA) begin
                cos0 = t_c0[c - PH_LAT];
                sin0 = t_s0[c - PH_LAT];
                cos1 = t_c1[c - PH_LAT];
                sin1 = t_s1[c - PH_LAT];
            end else begin
                rand_ph();
            end
            #1;
            chk_dut({tag, "_a"}, c, NA, addr_a, busy_a, done_a, re0_a, im0_a, re1_a, im1_a, exp_a);
            chk_dut({tag, "_b"}, c, NB, addr_b, busy_b, done_b, re0_b, im0_b, re1_b, im1_b, exp_b);
`ifdef DFT_BIN_ACC_MAG_EN
            if (c == PH_LAT + NA + DLY) begin
                chk({tag, "_a_mag0"}, 64'(mag0_a), 64'(expm_a[0]));
                chk({tag, "_a_mag1"}, 64'(mag1_a), 64'(expm_a[1]));
            end
`endif
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_re0"},  64'(re0_a),  64'(0));
        chk({tag, "_im0"},  64'(im0_a),  64'(0));
        chk({tag, "_re1"},  64'(re1_a),  64'(0));
        chk({tag, "_im1"},  64'(im1_a),  64'(0));
        chk({tag, "_busy"}, 64'(busy_a), 64'(0));
        chk({tag, "_done"}, 64'(done_a), 64'(0));
        chk({tag, "_addr"}, 64'(addr_a), 64'(0));
        chk({tag, "_b_re0"}, 64'(re0_b), 64'(0));
        chk({tag, "_b_busy"}, 64'(busy_b), 64'(0));
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        cos0 = '0; sin0 = '0; cos1 = '0; sin1 = '0;
        for (int k = 0; k < NA; k++) mem[k] = '0;
        repeat (2) @(posedge CK);
        #2;
        chk_zero("reset");
        RST = 1'b0;

        // Constant sample against full-scale cosine.
        rand_tabs();
        for (int k = 0; k < NA; k++) begin
            mem[k] = 18'h00100; t_c0[k] = 18'h1FFFF; t_s0[k] = 18'h0;
        end
        run_frame("dc", 0);
        chk("dc_a_re0_const", 64'(re0_a), 64'h0FFFF800);
        chk("dc_a_im0_const", 64'(im0_a), 64'h0);
        chk("dc_b_re0_const", 64'(re0_b), 64'h1FFFF00);

        // Largest single product.
        rand_tabs();
        mem[0] = 18'h1FFFF; t_c0[0] = 18'h1FFFF;
        run_frame("full", 0);
        chk("full_b_re0_const", 64'(re0_b), 64'h3FFFC0001);

        // Alternating sample against a 180-degree-step bin-1 phasor.
        rand_tabs();
        for (int k = 0; k < NA; k++) begin
            mem[k]  = (k % 2 == 0) ? 18'h10000 : 18'h30000;
            t_c1[k] = (k % 2 == 0) ? 18'h1FFFF : 18'h20001;
            t_s1[k] = 18'h0;
        end
        run_frame("alt", 0);
        chk("alt_a_re1_const", 64'(re1_a), 64'hFFFF80000);
        chk("alt_a_im1_const", 64'(im1_a), 64'h0);

        // Most negative sample and phasor everywhere.
        rand_tabs();
        for (int k = 0; k < NA; k++) begin
            mem[k] = 18'h20000; t_c0[k] = 18'h20000; t_s1[k] = 18'h20000;
        end
        run_frame("neg", 0);

        for (int r = 0; r < 3; r++) begin
            rand_tabs();
            run_frame($sformatf("rnd%0d", r), 0);
        end

        // Restart mid-frame at k=3: only the second frame may report done.
        rand_tabs();
        run_frame("rs1", PH_LAT + 3);
        rand_tabs();
        run_frame("rs2", 0);

        // START in the done cycle suppresses done and begins a fresh frame.
        rand_tabs();
        run_frame("dn1", PH_LAT + NA + DLY);
        rand_tabs();
        run_frame("dn2", 0);

        // Reset mid-accumulation, then idle with junk inputs, then a clean frame.
        rand_tabs();
        run_frame("rs", PH_LAT + 2);
        #1 RST = 1'b1;
        #1 chk_zero("rst_mid");
        @(posedge CK); #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CK); #1;
            rand_ph();
            #1;
            chk_zero($sformatf("rst_idle%0d", i));
        end
        rand_tabs();
        run_frame("post_rst", 0);

        // Results hold in IDLE while inputs change.
        for (int i = 0; i < 3; i++) begin
            @(posedge CK); #1;
            rand_ph();
            #1;
            chk($sformatf("hold_re0_%0d", i), 64'(re0_a), 64'(exp_a[0]));
            chk($sformatf("hold_im1_%0d", i), 64'(im1_a), 64'(exp_a[3]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
